// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM controller between two requesters.
//
// Port 0 is the pipeline MEM stage. Port 1 is a secondary master, such as a
// write-back buffer or an instruction refill.
//
// Each access runs through the controller's enable / not-ready handshake.
// Read data goes back to the port that won, and each port gets a stall signal.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rN_rd, rN_wr         port N read / write request, held until rN_done
//   rN_addr, rN_wdata    port N address / write data, snapshot at grant
//   rN_rdata             port N read data, valid with rN_done
//   rN_done              one-cycle completion pulse for port N
//   rN_stall             port N has a request pending that is not yet done
//   mem_r_en, mem_w_en   enables toward the SRAM controller
//   mem_addr, mem_wdata  registered address / write data toward the controller
//   mem_rdata            read data from the controller
//   mem_not_ready        controller busy, high from the issue cycle
//   arb_err              sticky flag, set when WAIT times out; cleared only by rst
//
// Optional build macro SRAM_ARB_RR_EN:
//   Defined   -> round-robin arbitration between the two ports.
//   Undefined -> fixed priority, port 0 wins.
module sram_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_rd,
   input  logic              r0_wr,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_done,
   output logic              r0_stall,
   input  logic              r1_rd,
   input  logic              r1_wr,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_done,
   output logic              r1_stall,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_not_ready,
   output logic              arb_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t            state;
   logic              grant;
   logic              op_rd;
   logic [CW-1:0]     cnt;
   logic              req0, req1, pick, sel_rd;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   assign req0 = r0_rd | r0_wr;
   assign req1 = r1_rd | r1_wr;
   assign r0_stall = req0 & ~r0_done;
   assign r1_stall = req1 & ~r1_done;
`ifdef SRAM_ARB_RR_EN
   logic last_grant;
   // On a tie, serve the port that was not served last. A lone requester always wins.
   assign pick = (req0 & req1) ? ~last_grant : ~req0;
`else
   assign pick = ~req0;
`endif
   // When rd and wr are both set, the access is a read.
   assign sel_rd    = pick ? r1_rd : r0_rd;
   assign sel_addr  = pick ? r1_addr : r0_addr;
   assign sel_wdata = pick ? r1_wdata : r0_wdata;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 1'b0;
         op_rd     <= 1'b0;
         cnt       <= '0;
         mem_r_en  <= 1'b0;
         mem_w_en  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
         r0_done   <= 1'b0;
         r1_done   <= 1'b0;
         arb_err   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         r0_done <= 1'b0;
         r1_done <= 1'b0;
         case (state)
            IDLE: if (req0 | req1) begin
               grant     <= pick;
               op_rd     <= sel_rd;
               mem_addr  <= sel_addr;
               mem_wdata <= sel_wdata;
               mem_r_en  <= sel_rd;
               mem_w_en  <= ~sel_rd;
`ifdef SRAM_ARB_RR_EN
               last_grant <= pick;
`endif
               state     <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (!mem_not_ready || cnt == T_LAST) begin
               // Completion has priority over the timeout in the same cycle.
               mem_r_en <= 1'b0;
               mem_w_en <= 1'b0;
               if (mem_not_ready)
                  arb_err <= 1'b1;
               else if (op_rd && grant)
                  r1_rdata <= mem_rdata;
               else if (op_rd)
                  r0_rdata <= mem_rdata;
               // If the requester dropped its request, the access still finishes but no done pulse is sent.
               r0_done <= ~grant & req0;
               r1_done <= grant & req1;
               state   <= DONE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
